// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types and sizes for the BCD display feed
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_SHIFT,
        ST_COMMIT
    } disp_state_t;

    localparam int NUM_DIGITS           = 4;
    localparam int BCD_DIGITS           = 5;
    localparam int VALUE_W              = 16;
    localparam int unsigned DEFAULT_REFRESH = 50000;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble nibble adjust: add 3 when the digit is 5 or more
module bcd_add3 (
    input  logic [3:0] nibble,
    output logic [3:0] adjusted
);

    assign adjusted = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/bcd_display_feed.sv
// rtl/bcd_display_feed.sv - periodic sampler converting a result word to four display nibbles
module bcd_display_feed
    import disp_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = DEFAULT_REFRESH
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [VALUE_W-1:0]      value,
    input  logic                    dec_mode,
    input  logic                    hold,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    overflow,
    output logic                    busy,
    output logic                    update
);

    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int DIG_W = 4 * NUM_DIGITS;

    disp_state_t        state;
    logic [CNT_W-1:0]   refresh_cnt;
    logic               tick;
    logic [4:0]         iter;
    logic [BCD_W-1:0]   acc;
    logic [BCD_W-1:0]   acc_adj;
    logic [VALUE_W-1:0] val_reg;
    logic               dec_reg;
    logic               acc_carry_unused;

    assign tick = (refresh_cnt == CNT_W'(REFRESH_CYCLES - 1));

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nibble   (acc[4*g +: 4]),
            .adjusted (acc_adj[4*g +: 4])
        );
    end

    // A 16-bit input never pushes the top BCD digit past 6, so this bit is always shifted out as 0.
    assign acc_carry_unused = acc_adj[BCD_W-1];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= tick ? '0 : refresh_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            iter     <= '0;
            acc      <= '0;
            val_reg  <= '0;
            dec_reg  <= 1'b0;
            digits   <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            update   <= 1'b0;
        end else begin
            update <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Ticks arriving while held or mid-conversion are simply lost.
                    if (tick && !hold) begin
                        state <= ST_SAMPLE;
                        busy  <= 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    val_reg <= value;
                    dec_reg <= dec_mode;
                    acc     <= '0;
                    iter    <= '0;
                    state   <= dec_mode ? ST_SHIFT : ST_COMMIT;
                end
                ST_SHIFT: begin
                    acc     <= {acc_adj[BCD_W-2:0], val_reg[VALUE_W-1]};
                    val_reg <= {val_reg[VALUE_W-2:0], 1'b0};
                    iter    <= iter + 1'b1;
                    if (iter == 5'(VALUE_W - 1)) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    if (dec_reg) begin
                        digits   <= acc[DIG_W-1:0];
                        overflow <= |acc[BCD_W-1:DIG_W];
                    end else begin
                        digits   <= val_reg;
                        overflow <= 1'b0;
                    end
                    update <= 1'b1;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_display_feed.sv
// tb/tb_bcd_display_feed.sv - self-checking bench for bcd_display_feed
module tb_bcd_display_feed;

    localparam int REFRESH = 20;

    logic        clock;
    logic        reset_n;
    logic [15:0] value;
    logic        dec_mode;
    logic        hold;
    logic [15:0] digits;
    logic        overflow;
    logic        busy;
    logic        update;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        string       name;
        logic [15:0] value;
        logic        dec;
        logic [15:0] exp_digits;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[5];

    bcd_display_feed #(.REFRESH_CYCLES(REFRESH)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .value    (value),
        .dec_mode (dec_mode),
        .hold     (hold),
        .digits   (digits),
        .overflow (overflow),
        .busy     (busy),
        .update   (update)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edges since reset release; the refresh tick is seen on edges that are multiples of REFRESH.
    always @(posedge clock) cyc <= reset_n ? cyc + 1 : 0;

    function automatic logic [16:0] model(input logic [15:0] v, input logic dec);
        int n;
        logic [15:0] d;
        n = int'(v);
        if (!dec) return {1'b0, v};
        d[15:12] = 4'((n / 1000) % 10);
        d[11:8]  = 4'((n / 100) % 10);
        d[7:4]   = 4'((n / 10) % 10);
        d[3:0]   = 4'(n % 10);
        return {(n > 9999), d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_update(output bit got);
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (update) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("update_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_phase(input int p);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (cyc % REFRESH == p) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) check("phase_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_vec(input string name, input logic [15:0] v, input logic dec,
                           input logic [15:0] exp_d, input logic exp_o);
        bit got;
        value    = v;
        dec_mode = dec;
        wait_update(got);
        if (got) begin
            check({name, "_digits"}, 32'(digits), 32'(exp_d));
            check({name, "_ovf"}, 32'(overflow), 32'(exp_o));
            check({name, "_latency"}, 32'(cyc % REFRESH), dec ? 32'd18 : 32'd2);
            check({name, "_busy_done"}, 32'(busy), 32'd0);
            @(negedge clock);
            check({name, "_pulse_width"}, 32'(update), 32'd0);
        end
    endtask

    initial begin
        bit          got;
        bit          saw;
        logic [16:0] m;
        logic [15:0] rv;
        logic        rd;
        logic [15:0] held;

        vecs[0] = '{"dec144",   16'd144,   1'b1, 16'h0144, 1'b0};
        vecs[1] = '{"dec65535", 16'd65535, 1'b1, 16'h5535, 1'b1};
        vecs[2] = '{"dec9999",  16'd9999,  1'b1, 16'h9999, 1'b0};
        vecs[3] = '{"hexbeef",  16'hBEEF,  1'b0, 16'hBEEF, 1'b0};
        vecs[4] = '{"dec10000", 16'd10000, 1'b1, 16'h0000, 1'b1};

        reset_n  = 1'b0;
        value    = 16'd0;
        dec_mode = 1'b1;
        hold     = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // Quiet period before the first tick
        saw = 1'b0;
        for (int i = 1; i < REFRESH; i++) begin
            @(negedge clock);
            if (digits != 16'h0 || overflow || busy || update) saw = 1'b1;
        end
        check("reset_quiet", 32'(saw), 32'd0);
        @(negedge clock);
        check("first_tick_cycle", 32'(cyc), 32'd20);
        check("first_tick_busy", 32'(busy), 32'd1);
        wait_update(got);
        check("first_update_cycle", 32'(cyc), 32'd38);
        check("first_digits", 32'(digits), 32'd0);
        check("first_ovf", 32'(overflow), 32'd0);

        for (int i = 0; i < 5; i++)
            run_vec(vecs[i].name, vecs[i].value, vecs[i].dec, vecs[i].exp_digits, vecs[i].exp_ovf);

        for (int i = 0; i < 20; i++) begin
            rv = 16'($urandom_range(0, 65535));
            rd = 1'($urandom_range(0, 1));
            m  = model(rv, rd);
            run_vec("rand", rv, rd, m[15:0], m[16]);
        end

        // Hold across two ticks with a changing input
        run_vec("pre_hold", 16'd2718, 1'b1, 16'h2718, 1'b0);
        held = digits;
        hold = 1'b1;
        saw  = 1'b0;
        for (int i = 0; i < 45; i++) begin
            value = 16'($urandom);
            @(negedge clock);
            if (update || busy) saw = 1'b1;
        end
        check("hold_no_update", 32'(saw), 32'd0);
        check("hold_digits", 32'(digits), 32'(held));
        hold = 1'b0;
        run_vec("post_hold", 16'd314, 1'b1, 16'h0314, 1'b0);

        // Input change while shifting must not reach the result
        value    = 16'd1234;
        dec_mode = 1'b1;
        wait_phase(0);
        wait_phase(5);
        check("shift_busy_a", 32'(busy), 32'd1);
        value    = 16'd4321;
        dec_mode = 1'b0;
        wait_update(got);
        if (got) check("late_change_digits", 32'(digits), 32'h1234);

        // Reset in the middle of SHIFT discards the conversion
        value    = 16'd9876;
        dec_mode = 1'b1;
        wait_phase(0);
        wait_phase(9);
        check("shift_busy_b", 32'(busy), 32'd1);
        reset_n = 1'b0;
        @(negedge clock);
        check("rst_digits", 32'(digits), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_update", 32'(update), 32'd0);
        reset_n = 1'b1;
        saw = 1'b0;
        for (int i = 1; i < REFRESH; i++) begin
            @(negedge clock);
            if (update || busy || digits != 16'h0) saw = 1'b1;
        end
        check("rst_no_partial", 32'(saw), 32'd0);
        run_vec("after_rst", 16'h0042, 1'b0, 16'h0042, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_display_feed.md
BCD_DISPLAY_FEED -- requirements
Module: bcd_display_feed

Interface
REQ-001 Parameter REFRESH_CYCLES, default 50000, SHALL set the sample period in clock cycles (1 ms at 50 MHz); legal range 20..2^20.
REQ-002 clock  input  1  SHALL be the single system clock; all state on rising edge.
REQ-003 reset_n  input  1  SHALL be a synchronous, active-low reset.
REQ-004 value  input  16  SHALL carry the CPU result word to display (low half of the watched register).
REQ-005 dec_mode  input  1  SHALL select the format: 1 for decimal BCD, 0 for hex passthrough.
REQ-006 hold  input  1  SHALL freeze the display when 1 by suppressing new samples.
REQ-007 digits  output  16  SHALL carry four display nibbles, [3:0] least significant, feeding the 7-segment decoders.
REQ-008 overflow  output  1  SHALL be 1 when the committed decimal value exceeds 9999.
REQ-009 busy  output  1  SHALL be 1 while a sample is in flight (SAMPLE, SHIFT or COMMIT).
REQ-010 update  output  1  SHALL pulse high for exactly one cycle when digits/overflow change register value set.

Function
REQ-011 Refresh counter SHALL count 0..REFRESH_CYCLES-1, wrap to 0, and assert tick on the terminal count.
- First tick occurs REFRESH_CYCLES cycles after reset release.
REQ-012 FSM states SHALL be IDLE, SAMPLE, SHIFT, COMMIT.
REQ-013 IDLE->SAMPLE SHALL occur on tick with hold=0.
- Ticks while hold=1, or while not IDLE, SHALL be dropped, not queued.
REQ-014 SAMPLE SHALL capture value and dec_mode into internal registers.
- Then: ->SHIFT if dec_mode=1; ->COMMIT if dec_mode=0.
- Input changes after SAMPLE SHALL NOT affect the in-flight conversion.
REQ-015 SHIFT SHALL run double-dabble on a 20-bit (5-digit) BCD accumulator for exactly 16 cycles, one bit per cycle, MSB first.
- Each cycle: every BCD nibble >=5 gets +3 before the left shift.
- 5-bit iteration counter; ->COMMIT after the 16th shift.
REQ-016 COMMIT SHALL load digits and overflow in the same cycle, assert update for that cycle, then ->IDLE.
- Decimal: digits = lower 4 BCD digits; overflow = (ten-thousands digit != 0).
- Hex: digits = sampled value; overflow = 0.
REQ-017 Latency tick->update SHALL be 18 cycles in decimal mode and 2 cycles in hex mode.
REQ-018 digits and overflow SHALL change only in COMMIT; outputs hold their values at all other times, including while hold=1.
REQ-019 busy SHALL be 0 in IDLE and 1 in SAMPLE, SHIFT and COMMIT.
REQ-020 The refresh counter SHALL run freely regardless of FSM state or hold.

Reset
REQ-021 With reset_n=0 at a clock edge, the following SHALL take effect on the next edge, including mid-conversion:
- FSM -> IDLE
- refresh counter, iteration counter, accumulator -> 0
- digits=16'h0000, overflow=0, busy=0, update=0
REQ-022 A conversion interrupted by reset SHALL be discarded, with no partial commit.

Structure
REQ-023 A shared package disp_pkg SHALL hold:
- the FSM state enum
- NUM_DIGITS=4, BCD_DIGITS=5, VALUE_W=16
- DEFAULT_REFRESH=50000
REQ-024 One combinational sub-module bcd_add3 SHALL implement the per-nibble conditional +3 and be instantiated BCD_DIGITS times.
REQ-025 All other logic (counter, FSM, accumulator) SHALL reside in bcd_display_feed.

Verification (REFRESH_CYCLES=20)
REQ-026 Reset, then hold all inputs static -> digits=0000, overflow=0, busy=0 until the first tick at cycle 20; decimal update at cycle 38.
REQ-027 value=16'd144, dec_mode=1 -> after update: digits=16'h0144, overflow=0, update high exactly one cycle.
REQ-028 value=16'd65535, dec_mode=1 -> digits=16'h5535, overflow=1; then value=9999 -> digits=16'h9999, overflow=0.
REQ-029 value=16'hBEEF, dec_mode=0 -> digits=16'hBEEF, overflow=0, update exactly 2 cycles after tick.
REQ-030 Mid-operation events:
- hold=1 across two ticks while value changes -> no update, digits unchanged.
- reset_n=0 at SHIFT cycle 8 -> all outputs zero next cycle, no update pulse.
- value changed during SHIFT -> committed result reflects the SAMPLE-time value.
